apb_multi_timer: RTL



---
 rtl/apb_multi_timer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/apb_multi_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_multi_timer                                              |
// | Description : NUM_CH independent APB3 down-counter timers, each with its   |
// |               own prescaler, periodic / one-shot / free-running mode and   |
// |               interrupt enable. Zero-wait-state target; PSLVERR flags      |
// |               unmapped addresses.                                          |
// | Ports       : PCLK, PRESETn         clock, async active-low reset          |
// |               PSEL/PENABLE/PWRITE   APB3 control                           |
// |               PADDR[7:0], PWDATA    byte address (bits [1:0] ignored), data|
// |               PRDATA/PREADY/PSLVERR APB3 response                          |
// |               TIMINT[NUM_CH-1:0]    registered per-channel interrupts      |
// |               TIMINT_ANY            registered OR of the interrupt terms   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module apb_multi_timer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int PRE_W  = 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [7:0]        PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [NUM_CH-1:0] TIMINT,
    output logic              TIMINT_ANY
);

    localparam logic [3:0] c_NUM_CH       = 4'(NUM_CH);
    localparam logic [1:0] c_MODE_ONESHOT = 2'b01;
    localparam logic [1:0] c_MODE_FREE    = 2'b10;

    logic              w_access;
    logic              w_err;
    logic              w_wr;
    logic              w_unused;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_ris;
    logic [NUM_CH-1:0] w_inten;
    logic [NUM_CH-1:0] w_irq_terms;
    logic [31:0]       w_rd_ch [NUM_CH];

    assign w_access = PSEL & PENABLE;
    // 0x00..0x7F: channel space, valid only for existing channels.
    // 0x80 is INTSTAT; everything from 0x84 upwards is unmapped.
    assign w_err    = PADDR[7] ? (PADDR[6:2] != 5'd0)
                               : ({1'b0, PADDR[6:4]} >= c_NUM_CH);
    assign w_wr     = w_access & PWRITE & ~w_err;
    assign PREADY   = 1'b1;
    assign PSLVERR  = w_access & w_err;
    assign w_unused = ^{PADDR[1:0], PWDATA};

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [CNT_W-1:0] r_load;
        logic [CNT_W-1:0] r_cnt;
        logic [PRE_W-1:0] r_pre;
        logic [PRE_W-1:0] r_pscnt;
        logic [1:0]       r_mode;
        logic             r_en;
        logic             r_inten;
        logic             r_ris;
        logic             w_wr_load;
        logic             w_wr_ctrl;
        logic             w_clr;
        logic             w_tick;
        logic             w_event;
        logic [31:0]      w_rd;

        assign w_sel[n]  = ~PADDR[7] & (PADDR[6:4] == 3'(n));
        assign w_wr_load = w_wr & w_sel[n] & (PADDR[3:2] == 2'd0);
        assign w_wr_ctrl = w_wr & w_sel[n] & (PADDR[3:2] == 2'd2);
        assign w_clr     = w_wr & w_sel[n] & (PADDR[3:2] == 2'd3) & PWDATA[0];
        // ">=" rather than "==" so lowering PRESCALE below the running
        // count fires on the next enabled cycle instead of wrapping.
        assign w_tick    = r_en & (r_pscnt >= r_pre);
        // A LOAD write on the same edge suppresses the expiry.
        assign w_event   = w_tick & (r_cnt == '0) & ~w_wr_load;

        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                r_load  <= '0;
                r_cnt   <= '0;
                r_pre   <= '0;
                r_pscnt <= '0;
                r_mode  <= 2'b00;
                r_en    <= 1'b0;
                r_inten <= 1'b0;
                r_ris   <= 1'b0;
            end else begin
                if (w_wr_ctrl) begin
                    r_en    <= PWDATA[0];
                    r_inten <= PWDATA[1];
                    r_mode  <= PWDATA[3:2];
                    r_pre   <= PWDATA[8 +: PRE_W];
                end else if (w_event && (r_mode == c_MODE_ONESHOT)) begin
                    r_en <= 1'b0;
                end

                if (w_wr_load) begin
                    r_load  <= PWDATA[CNT_W-1:0];
                    r_cnt   <= PWDATA[CNT_W-1:0];
                    r_pscnt <= '0;
                end else begin
                    // Rising EN restarts the prescaler phase.
                    if (w_wr_ctrl && PWDATA[0] && !r_en) begin
                        r_pscnt <= '0;
                    end else if (r_en) begin
                        r_pscnt <= w_tick ? '0 : r_pscnt + PRE_W'(1);
                    end

                    if (w_tick) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end else if (r_mode == c_MODE_FREE) begin
                            r_cnt <= '1;
                        end else if (r_mode == c_MODE_ONESHOT) begin
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_load;
                        end
                    end
                end

                // Set has priority over a same-edge software clear.
                if (w_event) begin
                    r_ris <= 1'b1;
                end else if (w_clr) begin
                    r_ris <= 1'b0;
                end
            end
        end

        always_comb begin
            w_rd = '0;
            case (PADDR[3:2])
                2'd0: w_rd = 32'(r_load);
                2'd1: w_rd = 32'(r_cnt);
                2'd2: begin
                    w_rd[0]          = r_en;
                    w_rd[1]          = r_inten;
                    w_rd[3:2]        = r_mode;
                    w_rd[8 +: PRE_W] = r_pre;
                end
                default: w_rd[0] = r_ris;
            endcase
        end

        assign w_rd_ch[n] = w_rd;
        assign w_ris[n]   = r_ris;
        assign w_inten[n] = r_inten;
    end

    assign w_irq_terms = w_ris & w_inten;

    always_comb begin
        PRDATA = '0;
        if (w_access && !w_err) begin
            if (PADDR[7]) begin
                PRDATA = 32'(w_irq_terms);
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (w_sel[i]) begin
                        PRDATA = w_rd_ch[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            TIMINT     <= '0;
            TIMINT_ANY <= 1'b0;
        end else begin
            TIMINT     <= w_irq_terms;
            TIMINT_ANY <= |w_irq_terms;
        end
    end

endmodule
`default_nettype wire
